// File: rtl/matrix_pkg.sv
// Shared types and sizing for the matrix entry controller and its neighbours.
package matrix_pkg;

   localparam int unsigned DATA_W  = 9;
   localparam int unsigned ELEMS   = 4;
   localparam int unsigned IDX_W   = $clog2(ELEMS);
   localparam int unsigned ADDR_W  = IDX_W + 1;
   localparam int unsigned TIMEOUT = 255;
   localparam int unsigned WDOG_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      WAIT_OP,
      RUN,
      SHOW
   } ctrl_state_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DET = 2'd3;

endpackage

// File: rtl/matrix_entry_ctrl.sv
// Sequences keypad entries into operands A/B, launches the ALU with a watchdog,
// then steps the result display.
module matrix_entry_ctrl
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              nrst,
   input  logic [DATA_W-1:0] keycode,
   input  logic              store_dig,
   input  logic              enter,
   input  logic              op_valid,
   input  logic [1:0]        op_sel,
   input  logic              alu_done,
   input  logic              next_disp,
   input  logic              clear,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              alu_start,
   output logic [1:0]        alu_op,
   output logic [IDX_W-1:0]  disp_idx,
   output logic              disp_valid,
   output logic              r_en,
   output logic              timeout_err
);

   ctrl_state_t        state;
   logic [IDX_W-1:0]   idx;
   logic [DATA_W-1:0]  held_code;
   logic               held_valid;
   logic [WDOG_W-1:0]  wdog;
   logic               r_en_pend;

   logic               commit;
   logic               last_elem;
   logic               mat;

   // A write happens on enter if a digit is held or arrives in the same cycle.
   assign commit    = enter && (store_dig || held_valid);
   assign last_elem = (idx == IDX_W'(ELEMS - 1));
   assign mat       = (state == LOAD_B);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= LOAD_A;
         idx         <= '0;
         held_code   <= '0;
         held_valid  <= 1'b0;
         wdog        <= '0;
         r_en_pend   <= 1'b0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         alu_start   <= 1'b0;
         alu_op      <= '0;
         disp_idx    <= '0;
         disp_valid  <= 1'b0;
         r_en        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         rf_we     <= 1'b0;
         alu_start <= 1'b0;
         r_en      <= r_en_pend;
         r_en_pend <= 1'b0;

         if (clear) begin
            state      <= LOAD_A;
            idx        <= '0;
            disp_idx   <= '0;
            held_valid <= 1'b0;
            disp_valid <= 1'b0;
         end else begin
            case (state)
               LOAD_A, LOAD_B: begin
                  if (commit) begin
                     rf_we      <= 1'b1;
                     rf_waddr   <= {mat, idx};
                     rf_wdata   <= store_dig ? keycode : held_code;
                     held_valid <= 1'b0;
                     if (last_elem) begin
                        idx <= '0;
                        if (state == LOAD_A) begin
                           state <= LOAD_B;
                        end else begin
                           state     <= WAIT_OP;
                           r_en_pend <= 1'b1;
                        end
                     end else begin
                        idx <= IDX_W'(idx + 1'b1);
                     end
                  end else if (store_dig) begin
                     held_code  <= keycode;
                     held_valid <= 1'b1;
                  end
               end

               WAIT_OP: begin
                  if (op_valid) begin
                     alu_op      <= op_sel;
                     alu_start   <= 1'b1;
                     wdog        <= '0;
                     timeout_err <= 1'b0;
                     state       <= RUN;
                  end
               end

               // Completion takes precedence over a coincident watchdog expiry.
               RUN: begin
                  wdog <= WDOG_W'(wdog + 1'b1);
                  if (alu_done) begin
                     state      <= SHOW;
                     disp_idx   <= '0;
                     disp_valid <= 1'b1;
                  end else if (wdog == WDOG_W'(TIMEOUT)) begin
                     timeout_err <= 1'b1;
                     state       <= LOAD_A;
                  end
               end

               SHOW: begin
                  if (op_valid) begin
                     alu_op      <= op_sel;
                     alu_start   <= 1'b1;
                     wdog        <= '0;
                     timeout_err <= 1'b0;
                     disp_valid  <= 1'b0;
                     state       <= RUN;
                  end else if (store_dig) begin
                     held_code  <= keycode;
                     held_valid <= 1'b1;
                     disp_valid <= 1'b0;
                     state      <= LOAD_A;
                  end else if (next_disp) begin
                     disp_idx <= IDX_W'(disp_idx + 1'b1);
                  end
               end

               default: state <= LOAD_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Directed self-checking bench for matrix_entry_ctrl.
module tb_matrix_entry_ctrl;
   import matrix_pkg::*;

   logic              clk = 1'b0;
   logic              nrst;
   logic [DATA_W-1:0] keycode;
   logic              store_dig, enter, op_valid, alu_done, next_disp, clear;
   logic [1:0]        op_sel;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              alu_start;
   logic [1:0]        alu_op;
   logic [IDX_W-1:0]  disp_idx;
   logic              disp_valid;
   logic              r_en;
   logic              timeout_err;

   int checks   = 0;
   int failures = 0;

   matrix_entry_ctrl dut (
      .clk(clk), .nrst(nrst), .keycode(keycode), .store_dig(store_dig),
      .enter(enter), .op_valid(op_valid), .op_sel(op_sel), .alu_done(alu_done),
      .next_disp(next_disp), .clear(clear), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .alu_start(alu_start), .alu_op(alu_op),
      .disp_idx(disp_idx), .disp_valid(disp_valid), .r_en(r_en),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 ns after it, pulse inputs then drop.
   task automatic cyc();
      @(posedge clk);
      #1;
      store_dig = 1'b0; enter = 1'b0; op_valid = 1'b0;
      alu_done = 1'b0; next_disp = 1'b0; clear = 1'b0;
   endtask

   task automatic write_elem(input string tag, input logic [DATA_W-1:0] v,
                             input logic [ADDR_W-1:0] a);
      keycode = v; store_dig = 1'b1;
      cyc();
      enter = 1'b1;
      cyc();
      chk({tag, "_we"}, 32'(rf_we), 32'd1);
      chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
      chk({tag, "_data"}, 32'(rf_wdata), 32'(v));
   endtask

   initial begin
      nrst = 1'b0; keycode = '0; op_sel = '0;
      store_dig = 1'b0; enter = 1'b0; op_valid = 1'b0;
      alu_done = 1'b0; next_disp = 1'b0; clear = 1'b0;
      cyc(); cyc();
      chk("reset_outs", 32'({rf_we, rf_waddr, rf_wdata, alu_start, alu_op, disp_idx,
                             disp_valid, r_en, timeout_err}), 32'd0);
      nrst = 1'b1;
      cyc();

      // Fill A and two of B, then reset asynchronously mid-cycle
      for (int i = 0; i < 6; i++)
         write_elem("pre", DATA_W'(9'h10 + i), ADDR_W'(i));
      #2 nrst = 1'b0;
      #1;
      chk("midreset_outs", 32'({rf_we, rf_waddr, rf_wdata, alu_start, alu_op, disp_idx,
                                disp_valid, r_en, timeout_err}), 32'd0);
      cyc();
      nrst = 1'b1;
      cyc();

      // Full load 1..8 at addresses 0..7, r_en one cycle after the 8th write
      for (int i = 0; i < 8; i++) begin
         write_elem("load", DATA_W'(i + 1), ADDR_W'(i));
         if (i == 7) chk("r_en_with_write", 32'(r_en), 32'd0);
      end
      cyc();
      chk("r_en_pulse", 32'(r_en), 32'd1);
      chk("rf_we_after_last", 32'(rf_we), 32'd0);
      cyc();
      chk("r_en_drop", 32'(r_en), 32'd0);

      // WAIT_OP ignores entry and display events
      keycode = 9'h55; store_dig = 1'b1; enter = 1'b1; next_disp = 1'b1;
      cyc();
      chk("waitop_no_we", 32'(rf_we), 32'd0);
      cyc();
      chk("waitop_no_we2", 32'(rf_we), 32'd0);

      // Normal run: MUL, done after 10 cycles, then step display
      op_sel = OP_MUL; op_valid = 1'b1;
      cyc();
      chk("run_start", 32'(alu_start), 32'd1);
      chk("run_op", 32'(alu_op), 32'(OP_MUL));
      cyc();
      chk("run_start_drop", 32'(alu_start), 32'd0);
      for (int i = 0; i < 8; i++) cyc();
      chk("run_not_shown", 32'(disp_valid), 32'd0);
      alu_done = 1'b1;
      cyc();
      chk("show_valid", 32'(disp_valid), 32'd1);
      chk("show_idx0", 32'(disp_idx), 32'd0);
      for (int i = 0; i < 5; i++) begin
         next_disp = 1'b1;
         cyc();
         chk("show_step", 32'(disp_idx), 32'((i + 1) % ELEMS));
      end

      // Timeout: new SUB from SHOW, no alu_done
      op_sel = OP_SUB; op_valid = 1'b1;
      cyc();
      chk("to_start", 32'(alu_start), 32'd1);
      chk("to_disp_off", 32'(disp_valid), 32'd0);
      for (int i = 0; i < 255; i++) cyc();
      chk("to_not_yet", 32'(timeout_err), 32'd0);
      cyc();
      chk("to_err", 32'(timeout_err), 32'd1);

      // Back in LOAD_A: op_valid must not launch, entry starts at addr 0
      op_valid = 1'b1;
      cyc();
      chk("loada_no_start", 32'(alu_start), 32'd0);
      write_elem("after_to", 9'h07, 3'd0);

      // Entry corner cases
      enter = 1'b1;
      cyc();
      chk("enter_alone", 32'(rf_we), 32'd0);
      keycode = 9'd5; store_dig = 1'b1; cyc();
      keycode = 9'd9; store_dig = 1'b1; cyc();
      chk("store_no_we", 32'(rf_we), 32'd0);
      enter = 1'b1; cyc();
      chk("overwrite_we", 32'(rf_we), 32'd1);
      chk("overwrite_addr", 32'(rf_waddr), 32'd1);
      chk("overwrite_data", 32'(rf_wdata), 32'd9);
      enter = 1'b1; cyc();
      chk("single_write", 32'(rf_we), 32'd0);
      keycode = 9'd3; store_dig = 1'b1; enter = 1'b1; cyc();
      chk("bypass_we", 32'(rf_we), 32'd1);
      chk("bypass_addr", 32'(rf_waddr), 32'd2);
      chk("bypass_data", 32'(rf_wdata), 32'd3);

      // clear coincident with the enter of element 3 of A
      keycode = 9'd4; store_dig = 1'b1; cyc();
      enter = 1'b1; clear = 1'b1; cyc();
      chk("clear_no_we", 32'(rf_we), 32'd0);
      chk("clear_keeps_err", 32'(timeout_err), 32'd1);
      enter = 1'b1; cyc();
      chk("clear_held_drop", 32'(rf_we), 32'd0);
      write_elem("post_clear", 9'h06, 3'd0);

      // Refill to WAIT_OP, then done coincident with expiry
      for (int i = 1; i < 8; i++)
         write_elem("refill", DATA_W'(9'h20 + i), ADDR_W'(i));
      cyc(); cyc();
      op_sel = OP_DET; op_valid = 1'b1;
      cyc();
      chk("co_start", 32'(alu_start), 32'd1);
      chk("co_err_cleared", 32'(timeout_err), 32'd0);
      for (int i = 0; i < 255; i++) cyc();
      alu_done = 1'b1;
      cyc();
      chk("co_show", 32'(disp_valid), 32'd1);
      chk("co_no_err", 32'(timeout_err), 32'd0);
      chk("co_op", 32'(alu_op), 32'(OP_DET));

      // store_dig in SHOW begins a new entry with that digit held
      keycode = 9'h11; store_dig = 1'b1; cyc();
      chk("show_exit", 32'(disp_valid), 32'd0);
      enter = 1'b1; cyc();
      chk("show_held_we", 32'(rf_we), 32'd1);
      chk("show_held_addr", 32'(rf_waddr), 32'd0);
      chk("show_held_data", 32'(rf_wdata), 32'h11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matrix_entry_ctrl.md
Name: matrix_entry_ctrl

Overview:
Sequencer between the binary key encoder and the matrix datapath. It collects encoded entries (one per store_dig/enter pair) into the operand register file. Matrix A fills first, then matrix B. It then launches the ALU with the chosen operation, watches for completion or timeout, and steps the display through result elements. It also returns the done-registering strobe (r_en) to the encoder.

Parameters:
DATA_W, 9, width of one keycode/matrix element
ELEMS, 4, elements per matrix (2x2), power of two
TIMEOUT, 255, max cycles in RUN before abort

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
keycode  in  DATA_W  encoded value from key encoder
store_dig  in  1  1-cycle pulse: keycode holds a completed digit
enter  in  1  1-cycle pulse: commit held digit as next element
op_valid  in  1  1-cycle pulse: operation button pressed
op_sel  in  2  operation code, sampled with op_valid
alu_done  in  1  1-cycle pulse from ALU: result written
next_disp  in  1  1-cycle pulse: advance displayed result element
clear  in  1  synchronous abort to LOAD_A from any state
rf_we  out  1  register-file write strobe
rf_waddr  out  $clog2(ELEMS)+1  {matrix_sel, element_idx}
rf_wdata  out  DATA_W  element value
alu_start  out  1  1-cycle start pulse
alu_op  out  2  latched op code
disp_idx  out  $clog2(ELEMS)  result element on display
disp_valid  out  1  result display active
r_en  out  1  1-cycle pulse to encoder: registration finished
timeout_err  out  1  sticky: RUN aborted on timeout

Behaviour:
- Reset (async, nrst=0): state LOAD_A; idx, disp_idx, held_code, held_valid, wdog = 0; every output 0.
- All outputs are registered. Pulse outputs are high exactly one cycle.
- Element entry (identical in LOAD_A and LOAD_B):
  - store_dig alone: held_code <= keycode, held_valid <= 1. A second store_dig overwrites the held value.
  - enter with held_valid=1: next cycle rf_we=1, rf_waddr={mat,idx}, rf_wdata=held_code. Then held_valid <= 0 and idx increments.
  - enter with held_valid=0: ignored, no write.
  - store_dig and enter in the same cycle: keycode is written directly (bypass) and held_valid ends 0.
- LOAD_A: mat=0. A write at idx=ELEMS-1 sets idx <= 0 and moves to LOAD_B.
- LOAD_B: mat=1. A write at idx=ELEMS-1 sets idx <= 0, pulses r_en the following cycle, and moves to WAIT_OP.
- WAIT_OP:
  - store_dig/enter/next_disp are ignored.
  - op_valid: alu_op <= op_sel, alu_start pulses next cycle, wdog <= 0, timeout_err <= 0, state RUN.
- RUN:
  - wdog increments each cycle.
  - alu_done: state SHOW, disp_idx <= 0, disp_valid <= 1.
  - wdog==TIMEOUT without alu_done: timeout_err <= 1, state LOAD_A.
  - alu_done in the same cycle as expiry: done wins, no error.
- SHOW:
  - next_disp: disp_idx increments, wrapping ELEMS-1 -> 0.
  - op_valid: starts a new op on the stored operands (disp_valid <= 0, alu_start pulse, state RUN).
  - store_dig: disp_valid <= 0, state LOAD_A, and the digit is captured as held_code (new entry begins).
- clear (any state): highest priority. State LOAD_A; idx, disp_idx, held_valid, disp_valid = 0; any same-cycle rf_we/alu_start is suppressed. timeout_err is preserved.
- Events not listed for a state are ignored. An op_valid during LOAD_A/LOAD_B never starts the ALU.

Decomposition:
- Package matrix_pkg:
  - ctrl_state_t enum {LOAD_A, LOAD_B, WAIT_OP, RUN, SHOW}.
  - Op codes OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DET=2'd3.
  - Constants DATA_W, ELEMS, IDX_W=$clog2(ELEMS).
- Sub-module: none required. The watchdog may be a separate watchdog_cnt (load/clear/expire) if reused by the ALU team.

Test Plan:
- Reset mid-LOAD_B (after 2 writes) -> all outputs 0, state LOAD_A, next write goes to addr 0.
- 8 (store_dig, enter) pairs with keycodes 1..8 -> rf_we pulses at addrs 0..7 with data 1..8; r_en pulses once, one cycle after the 8th write; state WAIT_OP.
- Data entry corner cases:
  - enter with no prior store_dig -> no rf_we.
  - store_dig 5, then store_dig 9, then enter -> single write of 9.
  - store_dig+enter in same cycle with keycode 3 -> write of 3.
- Normal run: op_valid with op_sel=2 -> alu_op=2, alu_start one cycle; alu_done after 10 cycles -> disp_valid=1, disp_idx=0; 5 next_disp pulses -> disp_idx 1,2,3,0,1.
- Timeout:
  - No alu_done -> timeout_err=1 at cycle TIMEOUT, state LOAD_A.
  - alu_done coincident with expiry -> SHOW, timeout_err=0.
- clear in the same cycle as the enter completing element 3 of A -> no rf_we, state LOAD_A, idx=0.
